// File: rtl/tone_synth.sv
// Square-wave note synthesizer: plays the indexed note as a glitch-free square wave,
// switching notes only on half-period boundaries with an optional silent gap.
module tone_synth #(
  parameter int                 CLK_FREQ   = 50_000_000,
  parameter logic signed [15:0] AMPLITUDE  = 16'sd8000,
  parameter int                 GAP_CYCLES = 500_000
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               enable_in,
  input  logic [3:0]         tone,
  output logic               audio_out,
  output logic signed [15:0] audio_sample,
  output logic               playing
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PLAY,
    S_GAP
  } state_t;

  // Half-period lengths in clk cycles: CLK_FREQ / (2 * note frequency).
  function automatic logic [16:0] half_of(input logic [2:0] t);
    case (t)
      3'd0:    half_of = 17'(CLK_FREQ / 880);
      3'd1:    half_of = 17'(CLK_FREQ / 988);
      3'd2:    half_of = 17'(CLK_FREQ / 1046);
      3'd3:    half_of = 17'(CLK_FREQ / 1174);
      3'd4:    half_of = 17'(CLK_FREQ / 1318);
      3'd5:    half_of = 17'(CLK_FREQ / 1396);
      3'd6:    half_of = 17'(CLK_FREQ / 1568);
      default: half_of = 17'(CLK_FREQ / 1760);
    endcase
  endfunction

  state_t          r_state,    w_state_nx;
  logic [16:0]     r_cnt,      w_cnt_nx;
  logic            r_sq,       w_sq_nx;
  logic [2:0]      r_cur_tone, w_cur_tone_nx;
  logic [GW-1:0]   r_gap_cnt,  w_gap_cnt_nx;
  logic            w_req;
  logic            w_boundary;

  assign w_req      = enable_in && !tone[3];
  assign w_boundary = (r_cnt == half_of(r_cur_tone) - 17'd1);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_sq       <= 1'b0;
      r_cur_tone <= '0;
      r_gap_cnt  <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_cnt      <= w_cnt_nx;
      r_sq       <= w_sq_nx;
      r_cur_tone <= w_cur_tone_nx;
      r_gap_cnt  <= w_gap_cnt_nx;
    end
  end

  always_comb begin
    w_state_nx    = r_state;
    w_cnt_nx      = r_cnt;
    w_sq_nx       = r_sq;
    w_cur_tone_nx = r_cur_tone;
    w_gap_cnt_nx  = r_gap_cnt;
    case (r_state)
      S_IDLE: begin
        w_cnt_nx = '0;
        w_sq_nx  = 1'b0;
        if (w_req) begin
          w_cur_tone_nx = tone[2:0];
          w_sq_nx       = 1'b1;
          w_state_nx    = S_PLAY;
        end
      end
      S_PLAY: begin
        w_cnt_nx = r_cnt + 17'd1;
        // Inputs are only acted on at the end of a half-period.
        if (w_boundary) begin
          w_cnt_nx = '0;
          if (!w_req) begin
            w_sq_nx    = 1'b0;
            w_state_nx = S_IDLE;
          end else if (tone[2:0] == r_cur_tone) begin
            w_sq_nx = ~r_sq;
          end else if (GAP_CYCLES > 0) begin
            w_sq_nx       = 1'b0;
            w_gap_cnt_nx  = '0;
            w_cur_tone_nx = tone[2:0];
            w_state_nx    = S_GAP;
          end else begin
            w_cur_tone_nx = tone[2:0];
            w_sq_nx       = ~r_sq;
          end
        end
      end
      S_GAP: begin
        w_sq_nx      = 1'b0;
        w_gap_cnt_nx = r_gap_cnt + GW'(1);
        if (!w_req) begin
          w_cnt_nx   = '0;
          w_state_nx = S_IDLE;
        end else if (r_gap_cnt == GAP_LAST) begin
          w_cur_tone_nx = tone[2:0];
          w_cnt_nx      = '0;
          w_sq_nx       = 1'b1;
          w_state_nx    = S_PLAY;
        end
      end
      default: begin
        w_cnt_nx   = '0;
        w_sq_nx    = 1'b0;
        w_state_nx = S_IDLE;
      end
    endcase
  end

  assign audio_out    = r_sq;
  assign playing      = (r_state != S_IDLE);
  assign audio_sample = (r_state == S_PLAY) ? (r_sq ? AMPLITUDE : -AMPLITUDE) : '0;

endmodule

// File: tb/tb_tone_synth.sv
// Randomized + directed bench for tone_synth, compared cycle by cycle against a
// segment-countdown reference model of the note player.
module tb_tone_synth;
  localparam int CLK_FREQ = 8800;
  localparam int GAP      = 4;
  localparam int AMP      = 8000;

  logic               clk = 1'b0;
  logic               resetN = 1'b0;
  logic               enable_in = 1'b0;
  logic [3:0]         tone = 4'd0;
  logic               audio_out;
  logic signed [15:0] audio_sample;
  logic               playing;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  tone_synth #(
    .CLK_FREQ  (CLK_FREQ),
    .AMPLITUDE (16'sd8000),
    .GAP_CYCLES(GAP)
  ) dut (
    .clk         (clk),
    .resetN      (resetN),
    .enable_in   (enable_in),
    .tone        (tone),
    .audio_out   (audio_out),
    .audio_sample(audio_sample),
    .playing     (playing)
  );

  // Reference model: mode 0 idle, 1 playing, 2 gap; remain counts cycles left in a segment.
  int freq [8] = '{440, 494, 523, 587, 659, 698, 784, 880};
  int m_mode = 0, m_level = 0, m_tone = 0, m_remain = 0, m_gap_left = 0;

  function automatic int half(input int t);
    return CLK_FREQ / (2 * freq[t]);
  endfunction

  function automatic logic signed [31:0] exp_out();
    return (m_mode == 1 && m_level == 1) ? 1 : 0;
  endfunction

  function automatic logic signed [31:0] exp_playing();
    return (m_mode != 0) ? 1 : 0;
  endfunction

  function automatic logic signed [31:0] exp_sample();
    if (m_mode != 1) return 0;
    return (m_level == 1) ? AMP : -AMP;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_level = 0; m_tone = 0; m_remain = 0; m_gap_left = 0;
  endtask

  task automatic model_step();
    bit req;
    int t;
    t   = int'(tone);
    req = enable_in && (t < 8);
    case (m_mode)
      0: if (req) begin
        m_mode = 1; m_tone = t; m_remain = half(t); m_level = 1;
      end
      1: begin
        m_remain--;
        if (m_remain == 0) begin
          if (!req) begin
            m_mode = 0; m_level = 0;
          end else if (t == m_tone) begin
            m_level = 1 - m_level; m_remain = half(m_tone);
          end else begin
            m_mode = 2; m_tone = t; m_gap_left = GAP; m_level = 0;
          end
        end
      end
      default: begin
        if (!req) begin
          m_mode = 0;
        end else begin
          m_gap_left--;
          if (m_gap_left == 0) begin
            m_mode = 1; m_tone = t; m_remain = half(t); m_level = 1;
          end
        end
      end
    endcase
  endtask

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".audio_out"}, audio_out, exp_out());
    check({tag, ".playing"}, playing, exp_playing());
    check({tag, ".audio_sample"}, audio_sample, exp_sample());
  endtask

  task automatic cycle();
    @(posedge clk);
    if (resetN) model_step();
    @(negedge clk);
    check_outputs("cyc");
  endtask

  // Assert reset between clock edges and confirm outputs clear without an edge.
  task automatic async_reset();
    #2 resetN = 1'b0;
    #1;
    check("arst.audio_out", audio_out, 0);
    check("arst.playing", playing, 0);
    check("arst.audio_sample", audio_sample, 0);
    model_reset();
    repeat (2) cycle();
    resetN = 1'b1;
  endtask

  task automatic run_until(input int mode, input int level, input int remain, input int budget);
    int n = 0;
    while (!(m_mode == mode && (level < 0 || m_level == level) &&
             (remain < 0 || m_remain == remain)) && n < budget) begin
      cycle();
      n++;
    end
    if (n >= budget) check("wait_timeout", 0, 1);
  endtask

  initial begin
    // Reset with a request already present
    resetN = 1'b0; enable_in = 1'b1; tone = 4'd0;
    #1;
    check("reset.audio_out", audio_out, 0);
    check("reset.playing", playing, 0);
    check("reset.audio_sample", audio_sample, 0);
    repeat (3) cycle();
    resetN = 1'b1;
    cycle();
    check("start_latency", audio_out, 1);
    check("start_playing", playing, 1);

    // Steady A
    repeat (100) cycle();

    // Note change A->E three cycles into a high half, then reset during the gap
    run_until(1, 1, half(0) - 3, 40);
    tone = 4'd4;
    run_until(2, -1, -1, 40);
    check("gap_playing", playing, 1);
    cycle();
    async_reset();
    repeat (30) cycle();

    // Stop two cycles into a high half of A_TWO
    tone = 4'd7;
    run_until(1, 1, half(7) - 2, 60);
    enable_in = 1'b0;
    repeat (10) cycle();
    check("stop_idle", playing, 0);

    // Invalid tone from idle, then during play
    enable_in = 1'b1; tone = 4'd9;
    repeat (30) cycle();
    check("invalid_idle", playing, 0);
    tone = 4'd2;
    repeat (13) cycle();
    tone = 4'd9;
    repeat (30) cycle();
    check("invalid_play", playing, 0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        enable_in = ($urandom_range(0, 9) != 0);
        tone = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 7))
                                          : 4'($urandom_range(8, 15));
      end
      if ($urandom_range(0, 399) == 0) async_reset();
      else cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
